demux_rr_sched: RTL and testbench
=================================

DEMUX_RR_SCHED -- requirements
Module: demux_rr_sched

Interface
REQ-001 Parameter: DW, default 8, payload width in bits.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: in_valid  input  1  upstream beat present.
REQ-005 Port: in_data  input  DW  upstream payload.
REQ-006 Port: in_ready  output  1  beat accepted when in_valid & in_ready at clk rise.
REQ-007 Port: dst_en  input  4  per-destination enable mask; bit i enables destination i.
REQ-008 Port: out_valid  output  4  one-hot valid, bit i for destination i; all zero when idle.
REQ-009 Port: out_data  output  DW  payload shared by all destinations.
REQ-010 Port: out_ready  input  4  per-destination ready.
REQ-011 Port: sel  output  2  index of the destination currently held (demux select).
REQ-012 Port: busy  output  1  high while a beat is held.

Function
REQ-013 Block SHALL be a one-entry buffered 1-to-4 round-robin demux scheduler with states IDLE (buffer empty) and HOLD (buffer full).
REQ-014 Round-robin pointer ptr (2 bits): target = first i with dst_en[i]=1, searching cyclically from ptr (ptr, ptr+1, ... mod 4).
REQ-015 in_ready SHALL be 1 when dst_en != 0 and (state = IDLE or (state = HOLD and out_ready[sel] = 1)); otherwise 0.
REQ-016 On accept: buffer <= in_data, sel <= target, ptr <= target+1 mod 4, state <= HOLD; latency in-to-out = 1 cycle.
REQ-017 In HOLD: out_valid = 4'b0001 << sel, out_data = buffer, busy = 1; in IDLE: out_valid = 0, busy = 0, out_data = buffer (don't-care to sinks).
REQ-018 Transfer to destination i occurs when out_valid[i] & out_ready[i]; on transfer without accept, state <= IDLE.
REQ-019 Simultaneous transfer and accept SHALL stay in HOLD with new buffer/sel (full throughput, one beat per cycle).
REQ-020 Held beat SHALL remain stable (sel, out_data, out_valid) until transferred; dst_en changes affect only later accepts.
REQ-021 dst_en = 0 SHALL stall input (in_ready = 0) without disturbing a held beat.
REQ-022 out_ready bits of non-selected destinations SHALL be ignored.
REQ-023 ptr wraps 3 -> 0; a single enabled destination receives every beat.

Reset
REQ-024 rst high SHALL immediately force state IDLE, ptr 0, sel 0, buffer 0, out_valid 0, busy 0, in_ready per REQ-015; a held beat is discarded.
REQ-025 Reset deassertion mid-stream: first beat after reset SHALL target lowest enabled index at or after 0.

Configuration
REQ-026 Macro DEMUX_RR_SCHED_CNT_EN defined: extra output cnt (output 32) = four 8-bit per-destination delivery counters, cnt[8i+7:8i] for destination i, each incremented on transfer to i, wrapping 255 -> 0, cleared by rst.
REQ-027 Macro undefined: cnt port and counters SHALL be absent; all other behaviour identical.

Verification
REQ-028 dst_en=4'hF, out_ready=4'hF, in_valid held 1 with data 0x10,0x11,0x12,0x13,0x14 -> out_valid 1,2,4,8,1 on consecutive cycles, out_data matches, in_ready constant 1.
REQ-029 dst_en=4'b1010, 4 beats -> sel sequence 1,3,1,3.
REQ-030 Hold 0xAB to dest 2 with out_ready[2]=0 for 5 cycles, out_ready=4'b1011 -> out_valid=4'b0100, out_data=0xAB stable, in_ready=0; raise out_ready[2] -> transfer, next beat accepted same cycle.
REQ-031 Assert rst while HOLD -> out_valid=0, busy=0, sel=0 same cycle; after release first beat goes to dest 0 with dst_en=4'hF.
REQ-032 With DEMUX_RR_SCHED_CNT_EN, 257 beats to dst_en=4'b0001 -> cnt[7:0]=1, other counters 0; dst_en=0 -> in_ready=0.

Source files
------------

// File: rtl/demux_rr_sched.sv
// demux_rr_sched: one-entry buffered 1-to-4 round-robin demux scheduler.
// A single beat is held; the next beat can be accepted in the same cycle the
// held beat is delivered, so throughput is one beat per cycle.
// Optional feature: define DEMUX_RR_SCHED_CNT_EN to add the 'cnt' output,
// four 8-bit wrapping per-destination delivery counters.
module demux_rr_sched #(
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  input  logic [3:0]    dst_en,
  output logic [3:0]    out_valid,
  output logic [DW-1:0] out_data,
  input  logic [3:0]    out_ready,
  output logic [1:0]    sel,
  output logic          busy
`ifdef DEMUX_RR_SCHED_CNT_EN
  ,
  output logic [31:0]   cnt
`endif
);

  typedef enum logic [0:0] {StIdle, StHold} state_e;

  state_e        state_q;
  logic [1:0]    ptr_q;
  logic [1:0]    sel_q;
  logic [DW-1:0] buf_q;
  logic [3:0]    out_valid_q;
  logic          busy_q;

  logic [1:0]    target;
  logic [1:0]    idx;
  logic          found;
  logic          accept;
  logic          xfer;

  // Round-robin search: first enabled destination at or after ptr, cyclically.
  always_comb begin
    target = ptr_q;
    found  = 1'b0;
    idx    = '0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!found && dst_en[idx]) begin
        target = idx;
        found  = 1'b1;
      end
    end
  end

  // Handshake decode; only the selected destination's ready matters.
  always_comb begin
    xfer     = (state_q == StHold) && out_ready[sel_q];
    in_ready = (dst_en != 4'b0000) && ((state_q == StIdle) || out_ready[sel_q]);
    accept   = in_valid && in_ready;
  end

  // Buffer FSM with registered outputs; accept has priority over plain transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      ptr_q       <= 2'd0;
      sel_q       <= 2'd0;
      buf_q       <= '0;
      out_valid_q <= 4'b0000;
      busy_q      <= 1'b0;
    end else if (accept) begin
      state_q     <= StHold;
      buf_q       <= in_data;
      sel_q       <= target;
      ptr_q       <= target + 2'd1;
      out_valid_q <= 4'b0001 << target;
      busy_q      <= 1'b1;
    end else if (xfer) begin
      state_q     <= StIdle;
      out_valid_q <= 4'b0000;
      busy_q      <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = buf_q;
  assign sel       = sel_q;
  assign busy      = busy_q;

`ifdef DEMUX_RR_SCHED_CNT_EN
  logic [7:0] cnt_q [4];

  // Per-destination delivery counters, wrapping at 8 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) cnt_q[i] <= 8'd0;
    end else if (xfer) begin
      cnt_q[sel_q] <= cnt_q[sel_q] + 8'd1;
    end
  end

  assign cnt = {cnt_q[3], cnt_q[2], cnt_q[1], cnt_q[0]};
`endif

endmodule

// File: tb/tb_demux_rr_sched.sv
// Self-checking bench for demux_rr_sched: directed scenarios plus randomized
// traffic checked against a cycle-level behavioural model.
module tb_demux_rr_sched;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [3:0] dst_en;
  logic [3:0] out_valid;
  logic [7:0] out_data;
  logic [3:0] out_ready;
  logic [1:0] sel;
  logic       busy;
`ifdef DEMUX_RR_SCHED_CNT_EN
  logic [31:0] cnt;
`endif

  int errors = 0;
  int checks = 0;

  demux_rr_sched #(.DW(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .dst_en    (dst_en),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .sel       (sel),
    .busy      (busy)
`ifdef DEMUX_RR_SCHED_CNT_EN
    ,
    .cnt       (cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Round-robin rule: first enabled index at or after p, cyclically.
  function automatic int first_en(input int p, input logic [3:0] en);
    for (int k = 0; k < 4; k++) begin
      if (en[(p + k) % 4]) return (p + k) % 4;
    end
    return p;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; dst_en = 4'hF; out_ready = 4'h0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; dst_en = 4'hF; in_valid = 1'b0; out_ready = 4'h0;
    #1;
    checks++; if (out_valid !== 4'b0000) begin errors++;
      $display("FAIL reset_valid got=%b want=0000", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (sel !== 2'd0) begin errors++; $display("FAIL reset_sel got=%0d want=0", sel); end
    checks++; if (out_data !== 8'h00) begin errors++;
      $display("FAIL reset_data got=%h want=00", out_data); end
    checks++; if (in_ready !== 1'b1) begin errors++;
      $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_full_rate();
    logic [3:0] ev;
    logic [7:0] ed;
    do_reset();
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      in_valid = 1'b1; ed = 8'(8'h10 + n); in_data = ed; dst_en = 4'hF; out_ready = 4'hF;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++;
        $display("FAIL full_rate_ready n=%0d got=%b want=1", n, in_ready); end
      @(posedge clk); #1;
      ev = 4'b0001 << (n % 4);
      checks++; if (out_valid !== ev) begin errors++;
        $display("FAIL full_rate_valid n=%0d got=%b want=%b", n, out_valid, ev); end
      checks++; if (out_data !== ed) begin errors++;
        $display("FAIL full_rate_data n=%0d got=%h want=%h", n, out_data, ed); end
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_sparse_mask();
    logic [1:0] es;
    do_reset();
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 8'($urandom); dst_en = 4'b1010; out_ready = 4'hF;
      @(posedge clk); #1;
      es = (n % 2 == 0) ? 2'd1 : 2'd3;
      checks++; if (sel !== es) begin errors++;
        $display("FAIL sparse_sel n=%0d got=%0d want=%0d", n, sel, es); end
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset();
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'hAB; dst_en = 4'b0100; out_ready = 4'hF;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 8'hCD; dst_en = 4'hF; out_ready = 4'b1011;
      #1;
      checks++; if (out_valid !== 4'b0100) begin errors++;
        $display("FAIL bp_valid n=%0d got=%b want=0100", n, out_valid); end
      checks++; if (out_data !== 8'hAB) begin errors++;
        $display("FAIL bp_data n=%0d got=%h want=ab", n, out_data); end
      checks++; if (in_ready !== 1'b0) begin errors++;
        $display("FAIL bp_ready n=%0d got=%b want=0", n, in_ready); end
    end
    @(negedge clk);
    out_ready = 4'hF;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++;
      $display("FAIL bp_release_ready got=%b want=1", in_ready); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 4'b1000) begin errors++;
      $display("FAIL bp_next_valid got=%b want=1000", out_valid); end
    checks++; if (out_data !== 8'hCD) begin errors++;
      $display("FAIL bp_next_data got=%h want=cd", out_data); end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_stall();
    do_reset();
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'h5A; dst_en = 4'b0010; out_ready = 4'h0;
    @(negedge clk);
    dst_en = 4'h0; in_data = 8'h77; out_ready = 4'hF;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++;
      $display("FAIL stall_ready got=%b want=0", in_ready); end
    checks++; if (out_valid !== 4'b0010 || out_data !== 8'h5A) begin errors++;
      $display("FAIL stall_hold got=%b/%h want=0010/5a", out_valid, out_data); end
    @(negedge clk);
    #1;
    checks++; if (busy !== 1'b0 || in_ready !== 1'b0) begin errors++;
      $display("FAIL stall_idle busy=%b rdy=%b want=0/0", busy, in_ready); end
    in_valid = 1'b0;
  endtask

  task automatic test_reset_mid_hold();
    do_reset();
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'h01; dst_en = 4'hF; out_ready = 4'hF;
    @(negedge clk);
    in_data = 8'h02;
    @(negedge clk);
    in_valid = 1'b0; out_ready = 4'h0;
    #1;
    checks++; if (sel !== 2'd1 || busy !== 1'b1) begin errors++;
      $display("FAIL rmid_pre sel=%0d busy=%b want=1/1", sel, busy); end
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 4'b0000 || busy !== 1'b0 || sel !== 2'd0) begin errors++;
      $display("FAIL rmid_reset valid=%b busy=%b sel=%0d want=0000/0/0", out_valid, busy, sel); end
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b1; in_data = 8'h33; dst_en = 4'hF; out_ready = 4'hF;
    @(posedge clk); #1;
    checks++; if (out_valid !== 4'b0001 || out_data !== 8'h33) begin errors++;
      $display("FAIL rmid_first valid=%b data=%h want=0001/33", out_valid, out_data); end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

`ifdef DEMUX_RR_SCHED_CNT_EN
  task automatic test_counters();
    do_reset();
    for (int n = 0; n < 257; n++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 8'(n); dst_en = 4'b0001; out_ready = 4'hF;
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (cnt !== 32'h0000_0001) begin errors++;
      $display("FAIL cnt_wrap got=%h want=00000001", cnt); end
    dst_en = 4'h0; in_valid = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++;
      $display("FAIL cnt_stall_ready got=%b want=0", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
  endtask
`endif

  task automatic test_random();
    int         m_hold, m_sel, m_ptr, tgt;
    logic [7:0] m_data;
    logic       exp_rdy;
    logic [3:0] exp_vld;
    do_reset();
    m_hold = 0; m_sel = 0; m_ptr = 0; m_data = 8'h00;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom);
      dst_en    = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom);
      out_ready = 4'($urandom);
      #1;
      exp_rdy = (dst_en != 4'h0) && (m_hold == 0 || out_ready[m_sel]);
      exp_vld = (m_hold != 0) ? (4'b0001 << m_sel) : 4'b0000;
      checks++; if (in_ready !== exp_rdy) begin errors++;
        $display("FAIL rand_ready i=%0d got=%b want=%b", i, in_ready, exp_rdy); end
      checks++; if (out_valid !== exp_vld) begin errors++;
        $display("FAIL rand_valid i=%0d got=%b want=%b", i, out_valid, exp_vld); end
      checks++; if (busy !== (m_hold != 0)) begin errors++;
        $display("FAIL rand_busy i=%0d got=%b want=%0d", i, busy, m_hold); end
      checks++; if (sel !== 2'(m_sel)) begin errors++;
        $display("FAIL rand_sel i=%0d got=%0d want=%0d", i, sel, m_sel); end
      if (m_hold != 0) begin
        checks++; if (out_data !== m_data) begin errors++;
          $display("FAIL rand_data i=%0d got=%h want=%h", i, out_data, m_data); end
      end
      if (in_valid && exp_rdy) begin
        tgt = first_en(m_ptr, dst_en);
        m_hold = 1; m_sel = tgt; m_ptr = (tgt + 1) % 4; m_data = in_data;
      end else if (m_hold != 0 && out_ready[m_sel]) begin
        m_hold = 0;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; dst_en = 4'hF; out_ready = 4'h0;
    test_reset();
    test_full_rate();
    test_sparse_mask();
    test_backpressure();
    test_stall();
    test_reset_mid_hold();
`ifdef DEMUX_RR_SCHED_CNT_EN
    test_counters();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
